stepper_cmd_sched: RTL and testbench
====================================

STEPPER_CMD_SCHED -- requirements
Module: stepper_cmd_sched

Interface
REQ-001 Parameter NCH, default 30: number of stepper channels served.
REQ-002 Parameter STEP_DIV, default 1000: system1000 cycles between step issue slots, minimum 2.
REQ-003 system1000  input  1  clock; all state updates on its rising edge.
REQ-004 system1000_rst  input  1  reset; asynchronous, active-high.
REQ-005 req_valid  input  1  a move request is present.
REQ-006 req_ready  output  1  the move request is accepted this cycle.
REQ-007 req_chan  input  5  target channel index.
REQ-008 req_dir  input  1  direction: 1 = forward, 0 = reverse.
REQ-009 req_steps  input  12  number of steps to issue; 0 is legal.
REQ-010 abort  input  1  synchronous clear of all pending steps.
REQ-011 cmd  output  17  step command word to the stepper register bank: bit16 = valid, bits15:11 = channel, bit10 = direction, bits9:0 = 0.
REQ-012 done_valid  output  1  one-cycle pulse: a channel's last step was issued.
REQ-013 done_chan  output  5  channel index qualified by done_valid.
REQ-014 busy  output  1  high while any channel has pending steps.
REQ-015 req_err  output  1  one-cycle pulse: a request was dropped (req_chan >= NCH).

Function
REQ-016 Per channel the block SHALL hold a 12-bit pending count and a 1-bit direction.
REQ-017 req_ready SHALL be combinational: high when req_valid=1, req_chan < NCH, the target's pending count is 0 and abort=0.
REQ-018 An accepted request SHALL load the count with req_steps and the direction with req_dir on the same edge.
REQ-019 A request with req_steps = 0 SHALL be accepted without loading and SHALL pulse done_valid/done_chan on the next cycle.
REQ-020 A request with req_chan >= NCH SHALL be dropped with req_err = 1 for one cycle, and no state SHALL change.
REQ-021 The prescaler SHALL count 0..STEP_DIV-1 and wrap to 0; a tick SHALL occur on the cycle the count equals STEP_DIV-1.
REQ-022 FSM states: IDLE (no pending channels), ARMED (pending, waiting for a tick), ISSUE (one cycle, drive cmd).
REQ-023 IDLE -> ARMED when any count is nonzero; ARMED -> ISSUE on tick; ISSUE -> ARMED if any count is still nonzero after the decrement, otherwise ISSUE -> IDLE.
REQ-024 In ISSUE the granted channel SHALL be the first nonzero channel in round-robin order, starting at last_grant+1 and wrapping from NCH-1 to 0.
REQ-025 The grant SHALL be combinational over all channels: a single cycle, with no serial scan.
REQ-026 In ISSUE: cmd[16] = 1, the channel and direction come from the grant, and on the same edge the count decrements by 1 and last_grant is set to the granted channel.
REQ-027 Outside ISSUE, cmd SHALL be all zero.
REQ-028 When a decrement takes a count from 1 to 0, done_valid SHALL pulse with done_chan = that channel in the cycle after ISSUE.
REQ-029 A request targeting the channel being decremented SHALL be refused, because its count is nonzero, and SHALL be accepted on a later cycle.
REQ-030 A new request to an idle channel in the ISSUE cycle SHALL be accepted; the grant SHALL ignore it until the next tick.
REQ-031 busy SHALL be the OR of all counts being nonzero, registered.
REQ-032 On abort=1, all counts SHALL clear, the FSM SHALL go to IDLE and the prescaler SHALL reset to 0.
REQ-033 abort SHALL produce no done pulses.
REQ-034 abort has priority over request acceptance and issue in the same cycle.
REQ-035 The prescaler SHALL free-run, apart from reset and abort.

Reset
REQ-036 While system1000_rst=1: all counts, directions, the prescaler and last_grant (= NCH-1) are 0, with the FSM in IDLE.
REQ-037 While system1000_rst=1: cmd, done_valid, done_chan, busy and req_err are 0.
REQ-038 Reset asserted mid-move SHALL discard all pending steps, with no further cmd until new requests arrive.

Verification
REQ-039 Single move: chan 3, dir 1, steps 2, STEP_DIV 4 -> cmd = 0x11C00 (valid, chan 3, fwd) at two ticks 4 cycles apart -> done_chan = 3 pulse -> busy = 0.
REQ-040 Round robin: chans 0, 5, 29 each given 2 steps -> cmd channel order 0, 5, 29, 0, 5, 29 -> three done pulses.
REQ-041 Refusal: request to chan 5 while it has 3 pending -> req_ready = 0; after chan 5's done pulse, the same request is accepted.
REQ-042 Bad index: req_chan = 30 -> req_err = 1 for one cycle, with no count change; req_steps = 0 on chan 7 -> done_chan = 7 the next cycle with no cmd.
REQ-043 Abort: during a move of 10 steps, assert abort -> cmd = 0 from the next cycle, busy = 0, no done pulse.
REQ-044 Async reset: pulse system1000_rst between prescaler edges mid-move -> all outputs are 0 immediately, with no cmd after release.

Source files
------------

// File: rtl/stepper_cmd_sched.sv
// Round-robin stepper command scheduler. Each channel holds a pending step count.
// One step is issued per prescaler tick, to the first pending channel after the last grant.
module stepper_cmd_sched #(
  parameter int NCH      = 30,
  parameter int STEP_DIV = 1000
) (
  input  logic        system1000,
  input  logic        system1000_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_chan,
  input  logic        req_dir,
  input  logic [11:0] req_steps,
  input  logic        abort,
  output logic [16:0] cmd,
  output logic        done_valid,
  output logic [4:0]  done_chan,
  output logic        busy,
  output logic        req_err
);

  localparam int            PW         = $clog2(STEP_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

  typedef enum logic [1:0] {IDLE, ARMED, ISSUE} state_t;

  state_t         state_q, state_d;
  logic [11:0]    count_q [NCH];
  logic [11:0]    count_d [NCH];
  logic [NCH-1:0] dir_q;
  logic [NCH-1:0] zpend_q, zpend_d;
  logic [PW-1:0]  presc_q;
  logic [4:0]     last_grant_q;

  logic           tick, chan_ok, target_idle, accept;
  logic           do_issue, issue_done, any_now, any_next;
  logic           grant_found, grant_dir;
  logic [4:0]     grant;
  logic [11:0]    grant_cnt;
  logic [NCH-1:0] z_all;
  logic           z_found;
  logic [4:0]     z_chan;

  function automatic int wrap(input int v);
    return (v >= NCH) ? v - NCH : v;
  endfunction

  assign tick    = (presc_q == PRESC_LAST);
  assign chan_ok = int'(req_chan) < NCH;

  always_comb begin : req_check
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    target_idle = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (req_chan == 5'(i)) target_idle = (count_q[i] == '0);
  end

  assign req_ready = req_valid && chan_ok && target_idle && !abort;
  assign accept    = req_ready;

  // Rotating priority evaluated across every channel at once, starting after last_grant.
  always_comb begin : rr_grant
    grant_found = 1'b0;
    grant       = '0;
    grant_dir   = 1'b0;
    grant_cnt   = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!grant_found && count_q[wrap(int'(last_grant_q) + k)] != '0) begin
        grant_found = 1'b1;
        grant       = 5'(wrap(int'(last_grant_q) + k));
        grant_dir   = dir_q[wrap(int'(last_grant_q) + k)];
        grant_cnt   = count_q[wrap(int'(last_grant_q) + k)];
      end
    end
  end

  assign do_issue   = (state_q == ISSUE) && grant_found;
  assign issue_done = do_issue && (grant_cnt == 12'd1);

  always_comb begin : count_next
    any_now  = 1'b0;
    any_next = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      count_d[i] = count_q[i];
      if (do_issue && grant == 5'(i))
        count_d[i] = count_q[i] - 12'd1;
      if (accept && req_chan == 5'(i) && req_steps != '0)
        count_d[i] = req_steps;
      if (abort)
        count_d[i] = '0;
      any_now  = any_now  | (count_q[i] != '0);
      any_next = any_next | (count_d[i] != '0);
    end
  end

  // Zero-step completions wait here if an issue completion owns the done port this cycle.
  always_comb begin : zero_done
    z_all   = zpend_q;
    z_found = 1'b0;
    z_chan  = '0;
    for (int i = 0; i < NCH; i++)
      if (accept && req_steps == '0 && req_chan == 5'(i)) z_all[i] = 1'b1;
    for (int i = 0; i < NCH; i++)
      if (!z_found && z_all[i]) begin
        z_found = 1'b1;
        z_chan  = 5'(i);
      end
    zpend_d = z_all;
    if (!issue_done && z_found)
      for (int i = 0; i < NCH; i++)
        if (z_chan == 5'(i)) zpend_d[i] = 1'b0;
    if (abort) zpend_d = '0;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_now) state_d = ARMED;
      ARMED:   if (tick) state_d = ISSUE;
      ISSUE:   state_d = any_next ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin : cmd_out
    cmd = '0;
    if (do_issue) cmd = {1'b1, grant, grant_dir, 10'd0};
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      last_grant_q <= 5'(NCH - 1);
      dir_q        <= '0;
      zpend_q      <= '0;
      busy         <= 1'b0;
      req_err      <= 1'b0;
      done_valid   <= 1'b0;
      done_chan    <= '0;
      // NOTE: the count array is reset because it must read as "nothing pending" right after reset.
      for (int i = 0; i < NCH; i++) count_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      presc_q <= (abort || tick) ? '0 : presc_q + PW'(1);
      zpend_q <= zpend_d;
      busy    <= any_next;
      req_err <= req_valid && !chan_ok;
      for (int i = 0; i < NCH; i++) begin
        count_q[i] <= count_d[i];
        if (accept && req_steps != '0 && req_chan == 5'(i)) dir_q[i] <= req_dir;
      end
      if (do_issue && !abort) last_grant_q <= grant;
      if (abort) begin
        done_valid <= 1'b0;
      end else if (issue_done) begin
        done_valid <= 1'b1;
        done_chan  <= grant;
      end else if (z_found) begin
        done_valid <= 1'b1;
        done_chan  <= z_chan;
      end else begin
        done_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stepper_cmd_sched.sv
// Self-checking bench for stepper_cmd_sched: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the scheduling rules.
module tb_stepper_cmd_sched;

  localparam int NCH = 30;
  localparam int SD  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [4:0]  req_chan = '0;
  logic        req_dir = 1'b0;
  logic [11:0] req_steps = '0;
  logic        abort = 1'b0;
  logic        req_ready;
  logic [16:0] cmd;
  logic        done_valid;
  logic [4:0]  done_chan;
  logic        busy;
  logic        req_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] cmd_q[$];
  int          cmd_cyc[$];
  int          done_q[$];
  int          done_cyc[$];

  // Behavioural model state
  int m_cnt[NCH];
  bit m_dir[NCH];
  int m_lg, m_presc, m_done_chan;
  bit m_issue, m_pend_prev, m_done, m_busy, m_err;

  stepper_cmd_sched #(.NCH(NCH), .STEP_DIV(SD)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_chan       (req_chan),
    .req_dir        (req_dir),
    .req_steps      (req_steps),
    .abort          (abort),
    .cmd            (cmd),
    .done_valid     (done_valid),
    .done_chan      (done_chan),
    .busy           (busy),
    .req_err        (req_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_req(input logic [4:0] c, input logic d, input logic [11:0] s, output logic rdy);
    @(negedge clk);
    req_valid = 1'b1; req_chan = c; req_dir = d; req_steps = s;
    #1 rdy = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect(input int n);
    cmd_q.delete(); cmd_cyc.delete(); done_q.delete(); done_cyc.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cmd[16]) begin cmd_q.push_back(cmd); cmd_cyc.push_back(i); end
      if (done_valid) begin done_q.push_back(int'(done_chan)); done_cyc.push_back(i); end
    end
  endtask

  task automatic wait_cmd(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (cmd[16]) found = 1'b1;
    end
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= NCH; k++)
      if (m_cnt[(m_lg + k) % NCH] != 0) return (m_lg + k) % NCH;
    return -1;
  endfunction

  task automatic model_init();
    foreach (m_cnt[i]) begin m_cnt[i] = 0; m_dir[i] = 1'b0; end
    m_lg = NCH - 1; m_presc = 0; m_done_chan = 0;
    m_issue = 0; m_pend_prev = 0; m_done = 0; m_busy = 0; m_err = 0;
  endtask

  // Advance the model across one rising edge with the given inputs applied.
  task automatic model_edge(input bit v, input int c, input bit d, input int s, input bit ab);
    bit pend_cur, tick, acc, nxt;
    int g;
    pend_cur = 1'b0;
    foreach (m_cnt[i]) if (m_cnt[i] != 0) pend_cur = 1'b1;
    tick  = (m_presc == SD - 1);
    m_err = v && (c >= NCH);
    if (ab) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_presc = 0; m_issue = 0; m_pend_prev = 0; m_done = 0; m_busy = 0;
      return;
    end
    acc = 1'b0;
    if (v && c < NCH) acc = (m_cnt[c] == 0);
    // A slot is used only if steps were pending in the cycle before and at the tick.
    nxt = tick && m_pend_prev && pend_cur && !m_issue;
    m_done = 1'b0;
    if (m_issue) begin
      g = rr_pick();
      if (g >= 0) begin
        m_cnt[g]--;
        m_lg = g;
        if (m_cnt[g] == 0) begin m_done = 1'b1; m_done_chan = g; end
      end
    end
    if (acc) begin m_cnt[c] = s; m_dir[c] = d; end
    m_busy = 1'b0;
    foreach (m_cnt[i]) if (m_cnt[i] != 0) m_busy = 1'b1;
    m_presc = (m_presc + 1) % SD;
    m_pend_prev = pend_cur;
    m_issue = nxt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd !== 17'h0) begin n_fail++; $display("FAIL reset_cmd: got %h want 0", cmd); end
    n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL reset_done_valid: got %b want 0", done_valid); end
    n_checks++; if (done_chan !== 5'd0) begin n_fail++; $display("FAIL reset_done_chan: got %0d want 0", done_chan); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL reset_req_err: got %b want 0", req_err); end
  endtask

  task automatic test_single_move();
    logic rdy;
    do_reset();
    drive_req(5'd3, 1'b1, 12'd2, rdy);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", rdy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_on: got %b want 1", busy); end
    collect(20);
    n_checks++;
    if (cmd_q.size() != 2) begin
      n_fail++; $display("FAIL single_cmd_count: got %0d want 2", cmd_q.size());
    end else begin
      n_checks++; if (cmd_q[0] !== 17'h11C00) begin n_fail++; $display("FAIL single_cmd0: got %h want 11c00", cmd_q[0]); end
      n_checks++; if (cmd_q[1] !== 17'h11C00) begin n_fail++; $display("FAIL single_cmd1: got %h want 11c00", cmd_q[1]); end
      n_checks++; if (cmd_cyc[1] - cmd_cyc[0] != SD) begin n_fail++; $display("FAIL single_cmd_gap: got %0d want %0d", cmd_cyc[1] - cmd_cyc[0], SD); end
      n_checks++;
      if (done_q.size() != 1 || done_q[0] != 3 || done_cyc[0] != cmd_cyc[1] + 1) begin
        n_fail++; $display("FAIL single_done: got %0d pulses want one for chan 3 right after last cmd", done_q.size());
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_off: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic rdy;
    int   exp_ch[6];
    bit   exp_dir[6];
    exp_ch  = '{0, 5, 29, 0, 5, 29};
    exp_dir = '{1, 0, 1, 1, 0, 1};
    do_reset();
    drive_req(5'd0, 1'b1, 12'd2, rdy);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rr_ready0: got %b want 1", rdy); end
    drive_req(5'd5, 1'b0, 12'd2, rdy);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rr_ready5: got %b want 1", rdy); end
    drive_req(5'd29, 1'b1, 12'd2, rdy);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rr_ready29: got %b want 1", rdy); end
    collect(40);
    n_checks++;
    if (cmd_q.size() != 6) begin
      n_fail++; $display("FAIL rr_cmd_count: got %0d want 6", cmd_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (int'(cmd_q[i][15:11]) != exp_ch[i] || cmd_q[i][10] !== exp_dir[i]) begin
          n_fail++; $display("FAIL rr_cmd%0d: got %h want chan %0d dir %0d", i, cmd_q[i], exp_ch[i], exp_dir[i]);
        end
      end
    end
    n_checks++;
    if (done_q.size() != 3) begin
      n_fail++; $display("FAIL rr_done_count: got %0d want 3", done_q.size());
    end else begin
      n_checks++;
      if (done_q[0] != 0 || done_q[1] != 5 || done_q[2] != 29) begin
        n_fail++; $display("FAIL rr_done_order: got %0d %0d %0d want 0 5 29", done_q[0], done_q[1], done_q[2]);
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy_off: got %b want 0", busy); end
  endtask

  task automatic test_refusal();
    logic rdy;
    bit   accepted;
    bit   dv_at_acc;
    int   dc_at_acc, cmds_before;
    do_reset();
    drive_req(5'd5, 1'b1, 12'd3, rdy);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL refuse_first_ready: got %b want 1", rdy); end
    drive_req(5'd5, 1'b0, 12'd1, rdy);
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL refuse_busy_chan: got %b want 0", rdy); end
    accepted = 1'b0; dv_at_acc = 1'b0; dc_at_acc = 0; cmds_before = 0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_chan = 5'd5; req_dir = 1'b0; req_steps = 12'd1;
      #1;
      if (cmd[16]) cmds_before++;
      if (req_ready) begin
        accepted = 1'b1; dv_at_acc = done_valid; dc_at_acc = int'(done_chan);
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_checks++; if (accepted !== 1'b1) begin n_fail++; $display("FAIL refuse_retry_accept: got %b want 1", accepted); end
    n_checks++; if (cmds_before != 3) begin n_fail++; $display("FAIL refuse_cmds_before: got %0d want 3", cmds_before); end
    n_checks++;
    if (dv_at_acc !== 1'b1 || dc_at_acc != 5) begin
      n_fail++; $display("FAIL refuse_accept_timing: got done %b chan %0d want done 1 chan 5", dv_at_acc, dc_at_acc);
    end
    collect(12);
    n_checks++;
    if (cmd_q.size() != 1 || cmd_q[0] !== 17'h12800) begin
      n_fail++; $display("FAIL refuse_second_move: got %0d cmds want one 12800", cmd_q.size());
    end
  endtask

  task automatic test_bad_index();
    logic rdy;
    do_reset();
    drive_req(5'd30, 1'b1, 12'd5, rdy);
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL bad_ready: got %b want 0", rdy); end
    @(negedge clk);
    n_checks++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL bad_err_pulse: got %b want 1", req_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_no_load: got busy %b want 0", busy); end
    @(negedge clk);
    n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL bad_err_one_cycle: got %b want 0", req_err); end
    drive_req(5'd7, 1'b1, 12'd0, rdy);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", rdy); end
    @(negedge clk);
    n_checks++; if (done_valid !== 1'b1) begin n_fail++; $display("FAIL zero_done_valid: got %b want 1", done_valid); end
    n_checks++; if (done_chan !== 5'd7) begin n_fail++; $display("FAIL zero_done_chan: got %0d want 7", done_chan); end
    n_checks++; if (cmd !== 17'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_quiet: got cmd %h busy %b want 0 0", cmd, busy); end
    collect(10);
    n_checks++;
    if (cmd_q.size() != 0 || done_q.size() != 0) begin
      n_fail++; $display("FAIL zero_after: got %0d cmds %0d dones want 0 0", cmd_q.size(), done_q.size());
    end
  endtask

  task automatic test_abort();
    logic rdy;
    bit   found;
    do_reset();
    drive_req(5'd9, 1'b1, 12'd10, rdy);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", rdy); end
    wait_cmd(20, found);
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL abort_wait_cmd: got %b want 1", found); end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd !== 17'h0) begin n_fail++; $display("FAIL abort_cmd: got %h want 0", cmd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done_valid); end
    collect(20);
    n_checks++;
    if (cmd_q.size() != 0 || done_q.size() != 0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d cmds %0d dones want 0 0", cmd_q.size(), done_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic rdy;
    bit   found;
    do_reset();
    drive_req(5'd2, 1'b0, 12'd5, rdy);
    wait_cmd(20, found);
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL areset_wait_cmd: got %b want 1", found); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (cmd !== 17'h0) begin n_fail++; $display("FAIL areset_cmd: got %h want 0", cmd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
    n_checks++;
    if (done_valid !== 1'b0 || done_chan !== 5'd0 || req_err !== 1'b0) begin
      n_fail++; $display("FAIL areset_outputs: got done %b chan %0d err %b want 0 0 0", done_valid, done_chan, req_err);
    end
    @(negedge clk);
    rst = 1'b0;
    collect(20);
    n_checks++;
    if (cmd_q.size() != 0 || done_q.size() != 0) begin
      n_fail++; $display("FAIL areset_quiet: got %0d cmds %0d dones want 0 0", cmd_q.size(), done_q.size());
    end
  endtask

  task automatic test_random();
    int          g, c, s, r;
    bit          v, d, ab, exp_ready;
    logic [16:0] exp_cmd;
    do_reset();
    model_init();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      v  = ($urandom_range(0, 99) < 35);
      r  = $urandom_range(0, 99);
      c  = (r < 5) ? $urandom_range(NCH, 31) : (r < 40) ? $urandom_range(0, NCH - 1) : $urandom_range(0, 3);
      d  = 1'($urandom_range(0, 1));
      s  = $urandom_range(1, 3);
      ab = ($urandom_range(0, 149) == 0);
      req_valid = v; req_chan = 5'(c); req_dir = d; req_steps = 12'(s); abort = ab;
      #1;
      g = rr_pick();
      exp_cmd = '0;
      if (m_issue && g >= 0) exp_cmd = 17'h10000 | (17'(g) << 11) | (m_dir[g] ? 17'h400 : 17'h0);
      exp_ready = 1'b0;
      if (v && c < NCH && !ab) exp_ready = (m_cnt[c] == 0);
      n_checks++; if (cmd !== exp_cmd) begin n_fail++; $display("FAIL rand_cmd cyc %0d: got %h want %h", cyc, cmd, exp_cmd); end
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, req_ready, exp_ready); end
      n_checks++; if (done_valid !== m_done) begin n_fail++; $display("FAIL rand_done cyc %0d: got %b want %b", cyc, done_valid, m_done); end
      if (m_done) begin
        n_checks++; if (int'(done_chan) != m_done_chan) begin n_fail++; $display("FAIL rand_done_chan cyc %0d: got %0d want %0d", cyc, done_chan, m_done_chan); end
      end
      n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, busy, m_busy); end
      n_checks++; if (req_err !== m_err) begin n_fail++; $display("FAIL rand_err cyc %0d: got %b want %b", cyc, req_err, m_err); end
      model_edge(v, c, d, s, ab);
      @(negedge clk);
    end
    req_valid = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_round_robin();
    test_refusal();
    test_bad_index();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
